data_mem_responder: RTL and testbench

- Responder (slave) end of the core's data-memory request interface: accepts request/we_re/mask/address/store data and returns valid plus load data.
- Holds a word-organised, byte-maskable RAM with a parameterised number of wait states, so the core's valid-handshake path is exercised with non-zero latency.
- Sits beside the core in the SoC/testbench top, driving the core's data_mem_valid and load_data_in inputs.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_byte_ram.sv | 28 ++
 rtl/data_mem_responder.sv | 171 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, store/load
// select values and the wait-state counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic WE_READ  = 1'b0;
  localparam logic WE_WRITE = 1'b1;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM built from four byte lanes: synchronous byte-enabled
// write and synchronous read-enabled read through a single address port.
module dmem_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  output logic [31:0]   rd_data
);

  logic [3:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        mem[addr][i] <= wr_data[8*i +: 8];
      end
    end
    if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory interface with WAIT_STATES latency.
// Optional feature: define DMEM_PERF_CNT_EN to add rd_count/wr_count counters.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address_in,
  input  logic [31:0] store_data_in,
  output logic        valid,
  output logic [31:0] load_data_out,
  output logic        err,
`ifdef DMEM_PERF_CNT_EN
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
`endif
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
    WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_t                state, next_state;
  logic [WAIT_CNT_W-1:0] cnt, next_cnt;
  logic                  commit;

  logic                  cap_we, cap_oor;
  logic [3:0]            cap_mask;
  logic [AW-1:0]         cap_idx;
  logic [31:0]           cap_data;

  logic                  in_oor;
  logic                  eff_we, eff_oor;
  logic [3:0]            eff_mask;
  logic [AW-1:0]         eff_idx;
  logic [31:0]           eff_data;

  logic [3:0]            ram_wr_en;
  logic                  ram_rd_en;
  logic [31:0]           ram_rd_data;
  logic                  ld_zero;

  assign in_oor = |(address_in >> (AW + 2));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // With zero wait states the commit happens on the accepting edge itself.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          if (WAIT_STATES == 0) begin
            next_state = RESP;
            commit     = 1'b1;
          end else begin
            next_state = WAIT;
            next_cnt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          next_state = RESP;
          commit     = 1'b1;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && request) begin
      cap_we   <= we_re;
      cap_oor  <= in_oor;
      cap_mask <= mask;
      cap_idx  <= address_in[AW+1:2];
      cap_data <= store_data_in;
    end
  end

  // In IDLE the live inputs describe the access being committed; later the captured copies do.
  always_comb begin
    eff_we   = cap_we;
    eff_oor  = cap_oor;
    eff_mask = cap_mask;
    eff_idx  = cap_idx;
    eff_data = cap_data;
    if (state == IDLE) begin
      eff_we   = we_re;
      eff_oor  = in_oor;
      eff_mask = mask;
      eff_idx  = address_in[AW+1:2];
      eff_data = store_data_in;
    end
  end

  always_comb begin
    ram_wr_en = '0;
    ram_rd_en = 1'b0;
    if (commit && rst && !eff_oor) begin
      if (eff_we == WE_WRITE) begin
        ram_wr_en = eff_mask;
      end else begin
        ram_rd_en = 1'b1;
      end
    end
  end

  dmem_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .addr    (eff_idx),
    .wr_en   (ram_wr_en),
    .wr_data (eff_data),
    .rd_en   (ram_rd_en),
    .rd_data (ram_rd_data)
  );

  // The RAM read register doubles as the load-data register; ld_zero masks it after reset or an out-of-range load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_zero <= 1'b1;
    end else if (commit && eff_we == WE_READ) begin
      ld_zero <= eff_oor;
    end
  end

  assign load_data_out = ld_zero ? '0 : ram_rd_data;
  assign valid         = (state == RESP);
  assign err           = valid && cap_oor;
  assign busy          = (state != IDLE);

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (commit && !eff_oor) begin
      if (eff_we == WE_WRITE) begin
        wr_count <= wr_count + 32'd1;
      end else begin
        rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: random and directed accesses are
// predicted by a word-array model; a negedge monitor checks every response.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int WS      = 2;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        request = 1'b0;
  logic        we_re = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [31:0] address_in = '0;
  logic [31:0] store_data_in = '0;
  logic        valid, err, busy;
  logic [31:0] load_data_out;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_count, wr_count;
  int          exp_rd = 0;
  int          exp_wr = 0;
`endif

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .request       (request),
    .we_re         (we_re),
    .mask          (mask),
    .address_in    (address_in),
    .store_data_in (store_data_in),
    .valid         (valid),
    .load_data_out (load_data_out),
    .err           (err),
`ifdef DMEM_PERF_CNT_EN
    .rd_count      (rd_count),
    .wr_count      (wr_count),
`endif
    .busy          (busy)
  );

  typedef struct packed {
    logic        is_load;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model [DEPTH];
  int          checks = 0;
  int          errors = 0;
  bit          mon_on = 1'b0;
  logic [31:0] last_load = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: memory is an array of words, out-of-range is any address bit above the word index.
  function automatic exp_t model_access(input logic we, input logic [3:0] m,
                                        input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   idx;
    e.is_load = !we;
    e.err     = (addr / (DEPTH * 4)) != 0;
    e.data    = '0;
    idx       = int'((addr / 4) % DEPTH);
    if (!e.err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (m[b]) model[idx][8*b +: 8] = data[8*b +: 8];
`ifdef DMEM_PERF_CNT_EN
        exp_wr++;
`endif
      end else begin
        e.data = model[idx];
`ifdef DMEM_PERF_CNT_EN
        exp_rd++;
`endif
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      if (valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got valid=1 expected no response at %0t", $time);
        end else begin
          mon_e = sb.pop_front();
          check("resp_err", {31'd0, err}, {31'd0, mon_e.err});
          if (mon_e.is_load) begin
            check("load_data", load_data_out, mon_e.data);
            last_load = mon_e.data;
          end else begin
            check("store_keeps_load_data", load_data_out, last_load);
          end
        end
      end else begin
        check("err_idle", {31'd0, err}, 32'd0);
        check("load_data_hold", load_data_out, last_load);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((busy || valid) && k < TIMEOUT) begin
      @(negedge clk);
      k++;
    end
    if (k >= TIMEOUT) check("idle_timeout", 32'(k), 32'(TIMEOUT - 1));
  endtask

  task automatic junk_inputs();
    request       = 1'($urandom_range(0, 1));
    we_re         = 1'($urandom_range(0, 1));
    mask          = 4'($urandom);
    address_in    = $urandom;
    store_data_in = $urandom;
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] m,
                               input logic [31:0] addr, input logic [31:0] data);
    int k;
    wait_idle();
    sb.push_back(model_access(we, m, addr, data));
    request       = 1'b1;
    we_re         = we;
    mask          = m;
    address_in    = addr;
    store_data_in = data;
    @(negedge clk);
    k = 1;
    while (!valid && k < TIMEOUT) begin
      junk_inputs();
      @(negedge clk);
      k++;
    end
    request = 1'b0;
    check("latency", 32'(k), 32'(WS + 1));
  endtask

  // Request held high with the same load: a new access every WS+2 cycles.
  task automatic back_to_back_loads(input logic [31:0] addr, input int n);
    int k;
    wait_idle();
    for (int i = 0; i < n; i++) sb.push_back(model_access(1'b0, 4'h0, addr, '0));
    request    = 1'b1;
    we_re      = 1'b0;
    address_in = addr;
    for (int i = 0; i < n; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!valid && k < TIMEOUT);
      if (i == n - 1) request = 1'b0;
      check("b2b_gap", 32'(k), (i == 0) ? 32'(WS + 1) : 32'(WS + 2));
    end
  endtask

  task automatic reset_mid_store();
    wait_idle();
    request       = 1'b1;
    we_re         = 1'b1;
    mask          = 4'hF;
    address_in    = 32'h20;
    store_data_in = 32'h2222_2222;
    @(negedge clk);
    request = 1'b0;
    mon_on  = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_valid", {31'd0, valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_load_data", load_data_out, 32'd0);
`ifdef DMEM_PERF_CNT_EN
    check("rst_rd_count", rd_count, 32'd0);
    check("rst_wr_count", wr_count, 32'd0);
    exp_rd = 0;
    exp_wr = 0;
`endif
    rst       = 1'b1;
    last_load = '0;
    @(negedge clk);
    mon_on = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_load_data", load_data_out, 32'd0);
`ifdef DMEM_PERF_CNT_EN
    check("reset_rd_count", rd_count, 32'd0);
    check("reset_wr_count", wr_count, 32'd0);
`endif
    rst    = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;

    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 4'hF, 32'(i * 4), $urandom);
    applyStimulus(1'b1, 4'hF, 32'hFFC, $urandom);

    applyStimulus(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 4'h0, 32'h10, '0);
    applyStimulus(1'b1, 4'b0001, 32'h10, 32'h0000_00AA);
    applyStimulus(1'b0, 4'h0, 32'h10, '0);
    applyStimulus(1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 4'hF, 32'h12, '0);

    applyStimulus(1'b0, 4'h0, 32'h0000_1000, '0);
    applyStimulus(1'b1, 4'hF, 32'h0000_1000, 32'h5555_5555);
    applyStimulus(1'b0, 4'h0, 32'h0, '0);
    applyStimulus(1'b0, 4'h0, 32'hFFC, '0);

    back_to_back_loads(32'h10, 3);

    applyStimulus(1'b1, 4'hF, 32'h20, 32'h1111_1111);
    reset_mid_store();
    applyStimulus(1'b0, 4'h0, 32'h20, '0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom | 32'h0000_1000;
      end else begin
        idx = $urandom_range(0, 32);
        if (idx == 32) idx = DEPTH - 1;
        a = 32'(idx * 4) | 32'($urandom_range(0, 3));
      end
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifdef DMEM_PERF_CNT_EN
    check("rd_count", rd_count, 32'(exp_rd));
    check("wr_count", wr_count, 32'(exp_wr));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
